// File: rtl/axi_st_pattest_seq.sv
// axi_st_pattest_seq: arms the full2half pattern checker, streams counting pattern words into it
// and tallies pass/fail verdicts over a programmed number of iterations.
module axi_st_pattest_seq #(
   parameter int PATGEN_MODE = 1,
   parameter int ITER_W      = 16,
   parameter int TIMEOUT_CYC = 4096,
   parameter int GUARD_CYC   = 4
) (
   input  logic                      rdclk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [8:0]                num_words,
   input  logic [ITER_W-1:0]         num_iter,
   input  logic [40*PATGEN_MODE-1:0] seed,
   input  logic                      chkr_fifo_full,
   input  logic [1:0]                patchkr_out,
   output logic                      patchkr_en,
   output logic [8:0]                patgen_cnt,
   output logic [40*PATGEN_MODE-1:0] patgen_din,
   output logic                      patgen_din_wr,
   output logic                      cntuspatt_en,
   output logic                      busy,
   output logic                      done,
   output logic [ITER_W-1:0]         pass_cnt,
   output logic [ITER_W-1:0]         fail_cnt,
   output logic                      timeout_seen
);
   localparam int DW = 40*PATGEN_MODE;
   localparam int TW = $clog2(TIMEOUT_CYC+1);
   localparam int GW = $clog2(GUARD_CYC+1);
   typedef enum logic [2:0] {IDLE, ARM, GEN, WAIT, UPDATE, FIN} state_t;
   state_t            state_q, state_d;
   logic [8:0]        cnt_q, cnt_d, wcnt_q, wcnt_d;
   logic [ITER_W-1:0] niter_q, niter_d, iter_q, iter_d, pass_q, pass_d, fail_q, fail_d;
   logic [DW-1:0]     word_q, word_d;
   logic [GW-1:0]     guard_q, guard_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              tseen_q, tseen_d, vpass_q, vpass_d;
   always_ff @(posedge rdclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         niter_q <= '0;
         iter_q  <= '0;
         pass_q  <= '0;
         fail_q  <= '0;
         word_q  <= '0;
         guard_q <= '0;
         tmo_q   <= '0;
         tseen_q <= 1'b0;
         vpass_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         niter_q <= niter_d;
         iter_q  <= iter_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         word_q  <= word_d;
         guard_q <= guard_d;
         tmo_q   <= tmo_d;
         tseen_q <= tseen_d;
         vpass_q <= vpass_d;
      end
   end
   // abort bypasses the whole FSM so strobes drop in the same cycle and all tallies hold
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      wcnt_d        = wcnt_q;
      niter_d       = niter_q;
      iter_d        = iter_q;
      pass_d        = pass_q;
      fail_d        = fail_q;
      word_d        = word_q;
      guard_d       = guard_q;
      tmo_d         = tmo_q;
      tseen_d       = tseen_q;
      vpass_d       = vpass_q;
      patchkr_en    = 1'b0;
      patgen_din_wr = 1'b0;
      done          = 1'b0;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               cnt_d   = num_words;
               niter_d = num_iter;
               word_d  = seed;
               pass_d  = '0;
               fail_d  = '0;
               tseen_d = 1'b0;
               iter_d  = '0;
               guard_d = '0;
               state_d = (num_iter == '0 || num_words == '0) ? FIN : ARM;
            end
            ARM: begin
               patchkr_en = (guard_q == '0);
               guard_d    = guard_q + GW'(1);
               if (guard_q == GW'(GUARD_CYC-1)) begin
                  guard_d = '0;
                  wcnt_d  = '0;
                  state_d = GEN;
               end
            end
            GEN: if (!chkr_fifo_full) begin
               patgen_din_wr = 1'b1;
               word_d        = word_q + DW'(1);
               wcnt_d        = wcnt_q + 9'd1;
               if (wcnt_d == cnt_q) begin
                  tmo_d   = '0;
                  state_d = WAIT;
               end
            end
            WAIT: begin
               tmo_d = tmo_q + TW'(1);
               if (patchkr_out[1]) begin
                  vpass_d = patchkr_out[0];
                  state_d = UPDATE;
               end else if (tmo_q == TW'(TIMEOUT_CYC-1)) begin
                  vpass_d = 1'b0;
                  tseen_d = 1'b1;
                  state_d = UPDATE;
               end
            end
            UPDATE: begin
               iter_d  = iter_q + ITER_W'(1);
               pass_d  = (vpass_q && pass_q != '1) ? pass_q + ITER_W'(1) : pass_q;
               fail_d  = (!vpass_q && fail_q != '1) ? fail_q + ITER_W'(1) : fail_q;
               state_d = (iter_d == niter_q) ? FIN : ARM;
            end
            FIN: begin
               done    = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end
   assign patgen_cnt   = cnt_q;
   assign patgen_din   = word_q;
   assign cntuspatt_en = 1'b0;
   assign busy         = (state_q != IDLE);
   assign pass_cnt     = pass_q;
   assign fail_cnt     = fail_q;
   assign timeout_seen = tseen_q;
endmodule

// File: tb/tb_axi_st_pattest_seq.sv
// tb_axi_st_pattest_seq: randomized and directed runs against a checker emulator and run-level model.
module tb_axi_st_pattest_seq;
   localparam int T = 64;
   localparam int G = 4;
   logic        rdclk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, chkr_fifo_full = 1'b0;
   logic [8:0]  num_words = '0;
   logic [15:0] num_iter = '0;
   logic [39:0] seed = '0;
   logic [1:0]  patchkr_out = 2'b00;
   logic        patchkr_en, patgen_din_wr, cntuspatt_en, busy, done, timeout_seen;
   logic [8:0]  patgen_cnt;
   logic [39:0] patgen_din;
   logic [15:0] pass_cnt, fail_cnt;
   int          n_cmp = 0, n_err = 0;
   int          dly [16];
   bit          good [16];
   always #5 rdclk = ~rdclk;
   axi_st_pattest_seq #(.PATGEN_MODE(1), .ITER_W(16), .TIMEOUT_CYC(T), .GUARD_CYC(G)) dut (
      .rdclk(rdclk), .rst_n(rst_n), .start(start), .abort(abort),
      .num_words(num_words), .num_iter(num_iter), .seed(seed),
      .chkr_fifo_full(chkr_fifo_full), .patchkr_out(patchkr_out),
      .patchkr_en(patchkr_en), .patgen_cnt(patgen_cnt), .patgen_din(patgen_din),
      .patgen_din_wr(patgen_din_wr), .cntuspatt_en(cntuspatt_en), .busy(busy), .done(done),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .timeout_seen(timeout_seen));
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic set_all(input int d, input bit g);
      for (int i = 0; i < 16; i++) begin
         dly[i]  = d;
         good[i] = g;
      end
   endtask
   // The emulated checker posts its verdict dly[i] cycles after the last word of iteration i
   // and clears it one cycle after seeing the arm pulse.
   task automatic run(input int nw, input int ni, input logic [39:0] sd, input int stall_pct,
                      input int st_at, input int st_len, input int ab_at, input bit rnd_start);
      int cyc = 0, nwr = 0, nen = 0, ndone = 0, done_cyc = -1, last_wr = -1, ab_cyc = -1;
      int el = -1, vi = 0, st_left = 0, exp_pass = 0, exp_fail = 0, iters, exp_wr, exp_en;
      bit exp_tmo = 1'b0, ab_now, ab_pend = 1'b0, clr = 1'b0, in_stall, fin = 1'b0;
      logic [39:0] exp_word = sd;
      iters  = (nw == 0 || ni == 0) ? 0 : (ab_at > 0 ? ab_at / nw : ni);
      exp_wr = (nw == 0 || ni == 0) ? 0 : (ab_at > 0 ? ab_at : nw * ni);
      exp_en = (nw == 0 || ni == 0) ? 0 : (ab_at > 0 ? ab_at / nw + 1 : ni);
      for (int i = 0; i < iters; i++) begin
         if (dly[i] > T) begin
            exp_fail++;
            exp_tmo = 1'b1;
         end else if (good[i]) exp_pass++;
         else exp_fail++;
      end
      num_words = 9'(nw);
      num_iter  = 16'(ni);
      seed      = sd;
      while (!fin) begin
         @(posedge rdclk);
         #1;
         if (clr) begin
            patchkr_out = 2'b00;
            clr = 1'b0;
         end
         if (el >= 0) begin
            el++;
            if (el == dly[vi]) begin
               patchkr_out = good[vi] ? 2'b11 : 2'b10;
               el = -1;
            end
         end
         start   = (cyc == 0) || (rnd_start && busy && $urandom_range(0, 9) == 0);
         abort   = ab_pend;
         ab_now  = ab_pend;
         ab_pend = 1'b0;
         if (ab_now) ab_cyc = cyc;
         in_stall = (st_left > 0);
         if (st_left > 0) st_left--;
         chkr_fifo_full = in_stall || ($urandom_range(0, 99) < stall_pct);
         #1;
         if (chkr_fifo_full) chk("stall_wr", patgen_din_wr, 0);
         if (in_stall) chk("stall_din", patgen_din, exp_word);
         if (ab_now) begin
            chk("abort_wr", patgen_din_wr, 0);
            chk("abort_en", patchkr_en, 0);
         end
         if (patgen_din_wr) begin
            chk("din", patgen_din, exp_word);
            exp_word++;
            nwr++;
            last_wr = cyc;
            if (nwr % nw == 0) begin
               vi = nwr / nw - 1;
               el = 0;
            end
            if (nwr == ab_at) ab_pend = 1'b1;
            if (nwr == st_at) st_left = st_len;
         end
         if (patchkr_en) begin
            nen++;
            clr = 1'b1;
            el  = -1;
         end
         if (done) begin
            ndone++;
            done_cyc = cyc;
         end
         if (cyc == 1) chk("patgen_cnt", patgen_cnt, 64'(nw));
         if (cyc > 0 && !busy) begin
            fin = 1'b1;
            if (ab_at > 0) chk("abort_idle", 64'(cyc - ab_cyc), 1);
         end
         cyc++;
         if (cyc > 20000) begin
            chk("cycle_budget", 1, 0);
            fin = 1'b1;
         end
      end
      start = 1'b0;
      abort = 1'b0;
      chkr_fifo_full = 1'b0;
      chk("writes", 64'(nwr), 64'(exp_wr));
      chk("done_cnt", 64'(ndone), (ab_at > 0) ? 0 : 1);
      chk("en_cnt", 64'(nen), 64'(exp_en));
      chk("pass_cnt", pass_cnt, 64'(exp_pass));
      chk("fail_cnt", fail_cnt, 64'(exp_fail));
      chk("timeout_seen", timeout_seen, 64'(exp_tmo));
      if (ni == 1 && nw > 0 && ab_at == 0)
         chk("wait_len", 64'(done_cyc - last_wr), 64'((dly[0] > T ? T : dly[0]) + 2));
      if (iters == 0 && ab_at == 0) chk("done_cyc", 64'(done_cyc), 1);
   endtask
   initial begin
      logic [63:0] r;
      #1;
      chk("rst_ctl", {patchkr_en, patgen_din_wr, cntuspatt_en, busy, done, timeout_seen}, 0);
      chk("rst_cnt", {pass_cnt, fail_cnt, patgen_cnt}, 0);
      chk("rst_din", patgen_din, 0);
      repeat (2) @(negedge rdclk);
      rst_n = 1'b1;
      set_all(3, 1'b1);
      run(8, 1, 40'h00_0000_0010, 0, 0, 0, 0, 1'b0);
      set_all(5, 1'b1);
      good[1] = 1'b0;
      run(4, 3, 40'h0, 0, 0, 0, 0, 1'b0);
      set_all(2, 1'b1);
      run(10, 1, 40'h12_3456_7890, 0, 4, 5, 0, 1'b0);
      set_all(100000, 1'b1);
      run(3, 1, 40'h0, 0, 0, 0, 0, 1'b0);
      set_all(T, 1'b1);
      run(3, 1, 40'h5, 0, 0, 0, 0, 1'b0);
      set_all(T + 1, 1'b1);
      run(3, 1, 40'h5, 0, 0, 0, 0, 1'b0);
      set_all(4, 1'b1);
      run(4, 1, 40'hFF_FFFF_FFFE, 0, 0, 0, 0, 1'b0);
      run(8, 2, 40'h100, 0, 0, 0, 3, 1'b0);
      run(4, 3, 40'h200, 0, 0, 0, 6, 1'b0);
      run(5, 0, 40'h300, 0, 0, 0, 0, 1'b0);
      run(0, 3, 40'h400, 0, 0, 0, 0, 1'b0);
      for (int k = 0; k < 12; k++) begin
         for (int i = 0; i < 16; i++) begin
            dly[i]  = $urandom_range(1, T + 3);
            good[i] = 1'($urandom_range(0, 1));
         end
         r = {32'($urandom), 32'($urandom)};
         run($urandom_range(1, 12), $urandom_range(1, 4), r[39:0], $urandom_range(0, 30),
             0, 0, 0, 1'b1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
